// File: rtl/inst_fetch_q.sv
// -----------------------------------------------------------------------------
// inst_fetch_q
//
// Instruction-fetch unit with a prefetch queue. It keeps its own fetch PC,
// issues word reads to a synchronous instruction memory (one-cycle read
// latency), buffers returned words in a QDEPTH-entry FIFO and presents the
// FIFO head to decode over a valid/ready handshake. A jump flushes the queue,
// squashes the in-flight read and redirects fetch.
//
// Parameters:
//   RESET_PC  first fetch address after reset (word aligned)
//   MEM_AW    instruction memory word-address width
//   QDEPTH    prefetch queue entries (power of 2, >= 2)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   jmp_vld, jmp_addr   redirect request and target (bits [1:0] ignored)
//   out_vld, out_rdy    head-of-queue handshake towards decode
//   out_pc, out_inst    head entry (zero when the queue is empty)
//   imem_en, imem_addr  read strobe and word address to instruction memory
//   imem_data           read data, valid the cycle after imem_en
// -----------------------------------------------------------------------------
module inst_fetch_q #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_AW   = 10,
    parameter int          QDEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jmp_vld,
    input  logic [31:0]       jmp_addr,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst,
    output logic              imem_en,
    output logic [MEM_AW-1:0] imem_addr,
    input  logic [31:0]       imem_data
);

    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW+1:0] QD_LIMIT = (PW+2)'(QDEPTH);

    logic [31:0]   fpc_reg;
    logic          rsp_vld_reg;
    logic [31:0]   rsp_pc_reg;
    logic [31:0]   q_pc_reg   [QDEPTH];
    logic [31:0]   q_inst_reg [QDEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;

    logic          not_empty;
    logic          pop;
    logic          push;
    logic          issue;
    logic [PW+1:0] occupancy;

    assign not_empty = (count_reg != '0);

    // Reset and jump both block the handshake so nothing is consumed in a
    // cycle whose queue contents are about to be discarded.
    assign out_vld = not_empty & ~jmp_vld & ~rst;
    assign pop     = out_vld & out_rdy;

    // Credit: entries held plus the read in flight, minus what leaves this
    // cycle. Including pop lets fetch resume the very cycle decode accepts.
    assign occupancy = {1'b0, count_reg} + (PW+2)'(rsp_vld_reg) - (PW+2)'(pop);
    assign issue     = ~jmp_vld & ~rst & (occupancy < QD_LIMIT);
    assign imem_en   = issue;
    assign imem_addr = fpc_reg[MEM_AW+1:2];

    // A response landing in a jump cycle belongs to the old path; drop it.
    assign push = rsp_vld_reg & ~jmp_vld & ~rst;

    assign out_pc   = (not_empty & ~rst) ? q_pc_reg[rd_ptr_reg]   : 32'h0;
    assign out_inst = (not_empty & ~rst) ? q_inst_reg[rd_ptr_reg] : 32'h0;

    // Control state: fetch PC, in-flight tracker, queue pointers and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_reg     <= RESET_PC;
            rsp_vld_reg <= 1'b0;
            rsp_pc_reg  <= 32'h0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
        end else if (jmp_vld) begin
            fpc_reg     <= jmp_addr & 32'hFFFF_FFFC;
            rsp_vld_reg <= 1'b0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
        end else begin
            if (issue) begin
                fpc_reg     <= fpc_reg + 32'd4;
                rsp_vld_reg <= 1'b1;
                rsp_pc_reg  <= fpc_reg;
            end else begin
                rsp_vld_reg <= 1'b0;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Queue storage: one register pair per entry, written when it is the
    // current write slot. Contents need no reset; count gates visibility.
    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    q_pc_reg[gi]   <= rsp_pc_reg;
                    q_inst_reg[gi] <= imem_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_inst_fetch_q.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_q
//
// Directed bench for inst_fetch_q (RESET_PC = 0x100, MEM_AW = 10, QDEPTH = 4).
// A behavioural one-cycle-latency memory returns word(a) = {16'hC0DE, 6'b0, a}.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit
// later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_inst_fetch_q;

    logic        clk = 1'b0;
    logic        rst;
    logic        jmp_vld;
    logic [31:0] jmp_addr;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data = 32'h0;

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_pc;

    inst_fetch_q #(
        .RESET_PC(32'h0000_0100),
        .MEM_AW  (10),
        .QDEPTH  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .jmp_vld  (jmp_vld),
        .jmp_addr (jmp_addr),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_pc   (out_pc),
        .out_inst (out_inst),
        .imem_en  (imem_en),
        .imem_addr(imem_addr),
        .imem_data(imem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [9:0] a);
        return {16'hC0DE, 6'b0, a};
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_data <= word(imem_addr);
    end

    task automatic cycle_start;
        @(posedge clk);
        #1;
    endtask

    task automatic look;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; jmp_vld = 1'b0; jmp_addr = 32'h0; out_rdy = 1'b0;
        cycle_start; cycle_start; look;
        checks++; if (out_vld !== 1'b0) $display("FAIL reset_out_vld got %b exp 0", out_vld); else passed++;
        checks++; if (out_pc !== 32'h0) $display("FAIL reset_out_pc got %h exp 0", out_pc); else passed++;
        checks++; if (out_inst !== 32'h0) $display("FAIL reset_out_inst got %h exp 0", out_inst); else passed++;
        checks++; if (imem_en !== 1'b0) $display("FAIL reset_imem_en got %b exp 0", imem_en); else passed++;
    endtask

    task automatic test_free_run;
        cycle_start; rst = 1'b0; out_rdy = 1'b1; look;
        checks++; if (imem_en !== 1'b1) $display("FAIL fr_c0_en got %b exp 1", imem_en); else passed++;
        checks++; if (imem_addr !== 10'h040) $display("FAIL fr_c0_addr got %h exp 040", imem_addr); else passed++;
        checks++; if (out_vld !== 1'b0) $display("FAIL fr_c0_vld got %b exp 0", out_vld); else passed++;
        cycle_start; look;
        checks++; if (out_vld !== 1'b0) $display("FAIL fr_c1_vld got %b exp 0", out_vld); else passed++;
        exp_pc = 32'h100;
        for (int k = 0; k < 8; k++) begin
            cycle_start; look;
            $display("free_run xfer vld=%b pc=%h inst=%h", out_vld, out_pc, out_inst);
            checks++; if (out_vld !== 1'b1) $display("FAIL fr_vld[%0d] got %b exp 1", k, out_vld); else passed++;
            checks++; if (out_pc !== exp_pc) $display("FAIL fr_pc[%0d] got %h exp %h", k, out_pc, exp_pc); else passed++;
            checks++; if (out_inst !== word(exp_pc[11:2])) $display("FAIL fr_inst[%0d] got %h exp %h", k, out_inst, word(exp_pc[11:2])); else passed++;
            checks++; if (imem_en !== 1'b1) $display("FAIL fr_en[%0d] got %b exp 1", k, imem_en); else passed++;
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_backpressure;
        int pulses;
        // Restart from an empty queue at the next expected PC so the stall
        // begins with nothing in flight.
        cycle_start; jmp_vld = 1'b1; jmp_addr = exp_pc; out_rdy = 1'b0; look;
        checks++; if (out_vld !== 1'b0) $display("FAIL bp_jmp_vld got %b exp 0", out_vld); else passed++;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            cycle_start; jmp_vld = 1'b0; look;
            if (imem_en === 1'b1) pulses++;
        end
        checks++; if (pulses !== 4) $display("FAIL bp_pulses got %0d exp 4", pulses); else passed++;
        checks++; if (imem_en !== 1'b0) $display("FAIL bp_full_en got %b exp 0", imem_en); else passed++;
        checks++; if (out_vld !== 1'b1) $display("FAIL bp_full_vld got %b exp 1", out_vld); else passed++;
        checks++; if (out_pc !== exp_pc) $display("FAIL bp_full_pc got %h exp %h", out_pc, exp_pc); else passed++;
        for (int k = 0; k < 8; k++) begin
            cycle_start; out_rdy = 1'b1; look;
            $display("backpressure xfer vld=%b pc=%h inst=%h", out_vld, out_pc, out_inst);
            if (k == 0) begin
                checks++; if (imem_en !== 1'b1) $display("FAIL bp_resume_en got %b exp 1", imem_en); else passed++;
            end
            checks++; if (out_vld !== 1'b1) $display("FAIL bp_vld[%0d] got %b exp 1", k, out_vld); else passed++;
            checks++; if (out_pc !== exp_pc) $display("FAIL bp_pc[%0d] got %h exp %h", k, out_pc, exp_pc); else passed++;
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_jump_full;
        for (int k = 0; k < 6; k++) begin
            cycle_start; out_rdy = 1'b0;
        end
        cycle_start; jmp_vld = 1'b1; jmp_addr = 32'h0000_0203; out_rdy = 1'b1; look;
        checks++; if (out_vld !== 1'b0) $display("FAIL jf_T_vld got %b exp 0", out_vld); else passed++;
        checks++; if (imem_en !== 1'b0) $display("FAIL jf_T_en got %b exp 0", imem_en); else passed++;
        cycle_start; jmp_vld = 1'b0; look;
        checks++; if (imem_en !== 1'b1) $display("FAIL jf_T1_en got %b exp 1", imem_en); else passed++;
        checks++; if (imem_addr !== 10'h080) $display("FAIL jf_T1_addr got %h exp 080", imem_addr); else passed++;
        checks++; if (out_vld !== 1'b0) $display("FAIL jf_T1_vld got %b exp 0", out_vld); else passed++;
        cycle_start; look;
        checks++; if (out_vld !== 1'b0) $display("FAIL jf_T2_vld got %b exp 0", out_vld); else passed++;
        exp_pc = 32'h200;
        for (int k = 0; k < 4; k++) begin
            cycle_start; look;
            $display("jump_full xfer vld=%b pc=%h inst=%h", out_vld, out_pc, out_inst);
            checks++; if (out_vld !== 1'b1) $display("FAIL jf_vld[%0d] got %b exp 1", k, out_vld); else passed++;
            checks++; if (out_pc !== exp_pc) $display("FAIL jf_pc[%0d] got %h exp %h", k, out_pc, exp_pc); else passed++;
            checks++; if (out_inst !== word(exp_pc[11:2])) $display("FAIL jf_inst[%0d] got %h exp %h", k, out_inst, word(exp_pc[11:2])); else passed++;
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_back_to_back;
        cycle_start; jmp_vld = 1'b1; jmp_addr = 32'h40; out_rdy = 1'b1; look;
        checks++; if (out_vld !== 1'b0) $display("FAIL bb_T_vld got %b exp 0", out_vld); else passed++;
        cycle_start; jmp_addr = 32'h80; look;
        checks++; if (out_vld !== 1'b0) $display("FAIL bb_T1_vld got %b exp 0", out_vld); else passed++;
        checks++; if (imem_en !== 1'b0) $display("FAIL bb_T1_en got %b exp 0", imem_en); else passed++;
        cycle_start; jmp_vld = 1'b0; look;
        checks++; if (imem_addr !== 10'h020) $display("FAIL bb_T2_addr got %h exp 020", imem_addr); else passed++;
        checks++; if (out_vld !== 1'b0) $display("FAIL bb_T2_vld got %b exp 0", out_vld); else passed++;
        cycle_start; look;
        checks++; if (out_vld !== 1'b0) $display("FAIL bb_T3_vld got %b exp 0", out_vld); else passed++;
        cycle_start; look;
        $display("back_to_back xfer vld=%b pc=%h inst=%h", out_vld, out_pc, out_inst);
        checks++; if (out_vld !== 1'b1) $display("FAIL bb_T4_vld got %b exp 1", out_vld); else passed++;
        checks++; if (out_pc !== 32'h80) $display("FAIL bb_T4_pc got %h exp 00000080", out_pc); else passed++;
        cycle_start; look;
        checks++; if (out_pc !== 32'h84) $display("FAIL bb_T5_pc got %h exp 00000084", out_pc); else passed++;
    endtask

    task automatic test_wrap;
        cycle_start; jmp_vld = 1'b1; jmp_addr = 32'hFFC; out_rdy = 1'b1; look;
        cycle_start; jmp_vld = 1'b0; look;
        checks++; if (imem_addr !== 10'h3FF) $display("FAIL wr_addr_top got %h exp 3ff", imem_addr); else passed++;
        cycle_start; look;
        checks++; if (imem_addr !== 10'h000) $display("FAIL wr_addr_zero got %h exp 000", imem_addr); else passed++;
        cycle_start; look;
        $display("wrap xfer vld=%b pc=%h inst=%h", out_vld, out_pc, out_inst);
        checks++; if (out_pc !== 32'hFFC) $display("FAIL wr_pc_top got %h exp 00000ffc", out_pc); else passed++;
        checks++; if (out_inst !== word(10'h3FF)) $display("FAIL wr_inst_top got %h exp %h", out_inst, word(10'h3FF)); else passed++;
        cycle_start; look;
        $display("wrap xfer vld=%b pc=%h inst=%h", out_vld, out_pc, out_inst);
        checks++; if (out_pc !== 32'h1000) $display("FAIL wr_pc_next got %h exp 00001000", out_pc); else passed++;
        checks++; if (out_inst !== word(10'h000)) $display("FAIL wr_inst_next got %h exp %h", out_inst, word(10'h000)); else passed++;
    endtask

    task automatic test_reset_mid;
        cycle_start; jmp_vld = 1'b1; jmp_addr = 32'h300; out_rdy = 1'b0; look;
        for (int k = 0; k < 4; k++) begin
            cycle_start; jmp_vld = 1'b0;
        end
        cycle_start; look;
        checks++; if (out_pc !== 32'h300) $display("FAIL rm_head_pc got %h exp 00000300", out_pc); else passed++;
        rst = 1'b1; jmp_vld = 1'b1; jmp_addr = 32'h500; look;
        checks++; if (out_vld !== 1'b0) $display("FAIL rm_rst_vld got %b exp 0", out_vld); else passed++;
        checks++; if (imem_en !== 1'b0) $display("FAIL rm_rst_en got %b exp 0", imem_en); else passed++;
        cycle_start; rst = 1'b0; jmp_vld = 1'b0; out_rdy = 1'b1; look;
        checks++; if (out_vld !== 1'b0) $display("FAIL rm_after_vld got %b exp 0", out_vld); else passed++;
        checks++; if (imem_en !== 1'b1) $display("FAIL rm_after_en got %b exp 1", imem_en); else passed++;
        checks++; if (imem_addr !== 10'h040) $display("FAIL rm_after_addr got %h exp 040", imem_addr); else passed++;
        cycle_start; look;
        cycle_start; look;
        $display("reset_mid xfer vld=%b pc=%h inst=%h", out_vld, out_pc, out_inst);
        checks++; if (out_vld !== 1'b1) $display("FAIL rm_restart_vld got %b exp 1", out_vld); else passed++;
        checks++; if (out_pc !== 32'h100) $display("FAIL rm_restart_pc got %h exp 00000100", out_pc); else passed++;
    endtask

    initial begin
        test_reset;
        test_free_run;
        test_backpressure;
        test_jump_full;
        test_back_to_back;
        test_wrap;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_q.md
# inst_fetch_q

Parametrised instruction-fetch unit with a prefetch queue, the successor to the single-register fetch stage. It keeps its own fetch PC and issues word reads to a synchronous instruction memory with one-cycle read latency. Returned words go into a QDEPTH-entry FIFO, and the FIFO head is presented to decode over a valid/ready handshake. A jump flushes the queue, squashes the in-flight read and redirects fetch. Placement: between the instruction memory and the IF/ID boundary of the RV32 core.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- MEM_AW, 10: instruction memory word-address width (memory holds 2^MEM_AW words).
- QDEPTH, 4: prefetch queue entries; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- jmp_vld  in  1  redirect request; has priority over everything else.
- jmp_addr  in  32  redirect target; bits [1:0] ignored and treated as 0.
- out_vld  out  1  queue head is valid for decode.
- out_rdy  in  1  decode accepts the head this cycle.
- out_pc  out  32  PC of the head entry.
- out_inst  out  32  instruction word of the head entry.
- imem_en  out  1  read strobe to the instruction memory.
- imem_addr  out  MEM_AW  word address, equal to fpc[MEM_AW+1:2].
- imem_data  in  32  read data, valid the cycle after imem_en was high.

## Operation

- State:
  - fpc: 32-bit fetch PC.
  - rsp_vld, rsp_pc: 1-bit and 32-bit registers tracking the in-flight read.
  - FIFO: QDEPTH entries of {pc, inst}; wr/rd pointers of log2(QDEPTH) bits; count of log2(QDEPTH)+1 bits.
- pop = out_vld & out_rdy.
- out_vld = (count != 0) & ~jmp_vld.
  - In a jump cycle no transfer ever occurs, even if out_rdy = 1.
- out_pc and out_inst are driven 0 whenever count == 0; otherwise they show the head entry.
- Issue rule: imem_en = ~jmp_vld & (count + rsp_vld - pop < QDEPTH).
  - When issuing: fpc <= fpc + 4, modulo 2^32.
  - When issuing: rsp_vld <= 1 and rsp_pc <= fpc.
  - When not issuing: rsp_vld <= 0.
- Response: if rsp_vld = 1 and jmp_vld = 0, {rsp_pc, imem_data} is pushed into the FIFO.
  - The credit rule guarantees the push never meets a full FIFO.
  - Push and pop in the same cycle leave count unchanged.
- Jump, when jmp_vld = 1:
  - count <= 0 and both pointers <= 0.
  - rsp_vld <= 0; the response arriving this cycle is discarded.
  - fpc <= {jmp_addr[31:2], 2'b00}.
  - No issue this cycle.
- Wrap-around:
  - FIFO pointers wrap modulo QDEPTH.
  - imem_addr wraps naturally with fpc; fetching past the top of memory aliases to word 0.
- Reset, when rst = 1 (overrides jmp_vld, including mid-operation):
  - fpc <= RESET_PC; count, pointers and rsp_vld <= 0.
  - Consequence: out_vld = 0, out_pc = 0, out_inst = 0, imem_en = 0 during the reset cycle.

## Timing

- Reset released before cycle 0:
  - Cycle 0: imem_en = 1, imem_addr = RESET_PC >> 2.
  - Cycle 1: the word is pushed.
  - Cycle 2: out_vld = 1, out_pc = RESET_PC.
- Jump at cycle T:
  - Cycle T: out_vld = 0.
  - Cycle T+1: the read of the jump target issues.
  - Cycle T+3: the target appears at the head, with out_vld = 1 if no further jump.
- Throughput: with out_rdy held high, one instruction per cycle and no bubbles, for any QDEPTH >= 2.
- Backpressure: with out_rdy = 0, exactly QDEPTH entries accumulate, then imem_en drops.
  - The first cycle out_rdy returns to 1, imem_en rises again in that same cycle, because the credit includes pop.
- All outputs except out_vld, imem_en and out_pc/out_inst (zero muxing) come straight from registers.
  - out_vld and imem_en depend combinationally on jmp_vld, out_rdy and state only, never on imem_data.

## Test plan

- Reset then free-run: RESET_PC = 0x100, out_rdy = 1.
  - Required: out_vld from cycle 2; out_pc = 0x100, 0x104, 0x108 … one per cycle; out_inst = memory words 0x40, 0x41 ….
- Backpressure: QDEPTH = 4, out_rdy = 0 for 10 cycles.
  - Required: exactly 4 imem_en pulses; count saturates at 4.
  - After out_rdy = 1: PCs continue in order with no gaps or duplicates.
- Jump with a full queue: jmp_vld = 1, jmp_addr = 0x203, out_rdy = 1 in the same cycle.
  - Required: no transfer in the jump cycle; imem_addr = 0x80 at T+1; out_pc = 0x200 at T+3.
  - Required: no pre-jump PC is ever presented afterwards.
- Back-to-back jumps: jumps to 0x40 at T and to 0x80 at T+1.
  - Required: the 0x40 fetch is squashed; the first out_pc is 0x80, at T+4.
- Wrap: MEM_AW = 4, start at fpc = 0x3C.
  - Required: imem_addr goes 15 then 0; out_pc goes 0x3C then 0x40.
- Reset mid-stream: rst asserted for one cycle with 3 entries queued and a jump pending.
  - Required: out_vld = 0 the next cycle; fetch restarts at RESET_PC, ignoring jmp_addr.
